multi_pulse_stretch: RTL

Multi-channel, single-clock pulse detector and stretcher. Each channel detects edges on a synchronous input and turns each detected event into a fixed-length output pulse, separated from the next by at least one low cycle. Events that arrive while a channel is busy are queued, not merged. It sits between fast single-cycle event sources and consumers that sample on a clock enable or at a lower effective rate. It generalises the two-clock single-pulse handshake into N channels, edge modes, programmable stretch length and event queuing.

---
 rtl/multi_pulse_stretch.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/multi_pulse_stretch.sv
// Multi-channel edge detector and pulse stretcher. Each detected edge becomes a
// STRETCH-cycle high pulse followed by a low gap cycle, with a saturating per-channel event queue.
module multi_pulse_stretch #(
  parameter int unsigned CH      = 4,
  parameter int unsigned MODE    = 0,
  parameter int unsigned STRETCH = 4,
  parameter int unsigned QW      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    data_in,
  input  logic [CH-1:0]    clr,
  output logic [CH-1:0]    dataout,
  output logic [CH*QW-1:0] pend,
  output logic [CH-1:0]    ovf
);

  localparam int unsigned SW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
  localparam logic [SW-1:0] ScLoad = SW'(STRETCH - 1);
  localparam logic [QW-1:0] QMax = '1;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StGap
  } state_e;

  logic [CH-1:0] prev_q;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= data_in;
    end
  end

  assign rise = data_in & ~prev_q;
  assign fall = ~data_in & prev_q;

  always_comb begin
    if (MODE == 0) begin
      ev = rise;
    end else if (MODE == 1) begin
      ev = fall;
    end else begin
      ev = rise | fall;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_e        state_q, state_d;
    logic [SW-1:0] sc_q, sc_d;
    logic [QW-1:0] q_q, q_d;
    logic          out_q;
    logic          ovf_q, ovf_d;
    logic          inc;
    logic          dec;
    logic          drop;

    always_comb begin
      state_d = state_q;
      sc_d    = sc_q;
      inc     = 1'b0;
      dec     = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ev[i]) begin
            state_d = StHigh;
            sc_d    = ScLoad;
          end
        end
        StHigh: begin
          inc = ev[i];
          if (sc_q != '0) begin
            sc_d = sc_q - SW'(1);
          end else begin
            state_d = StGap;
          end
        end
        StGap: begin
          // With an empty queue a gap-cycle event is served directly, not queued.
          dec = (q_q != '0);
          inc = ev[i] && (q_q != '0);
          if ((q_q != '0) || ev[i]) begin
            state_d = StHigh;
            sc_d    = ScLoad;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_comb begin
      q_d  = q_q;
      drop = 1'b0;
      if (inc && !dec) begin
        if (q_q == QMax) begin
          drop = 1'b1;
        end else begin
          q_d = q_q + QW'(1);
        end
      end else if (dec && !inc) begin
        q_d = q_q - QW'(1);
      end
      // A new drop beats a coincident clear.
      ovf_d = ovf_q;
      if (drop) begin
        ovf_d = 1'b1;
      end else if (clr[i]) begin
        ovf_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StIdle;
        sc_q    <= '0;
        q_q     <= '0;
        out_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        sc_q    <= sc_d;
        q_q     <= q_d;
        out_q   <= (state_d == StHigh);
        ovf_q   <= ovf_d;
      end
    end

    assign dataout[i]          = out_q;
    assign pend[i*QW +: QW]    = q_q;
    assign ovf[i]              = ovf_q;
  end

endmodule
